sonar_varredura_uc: RTL and testbench
=====================================

Name: sonar_varredura_uc

Overview:
Sequencing controller for the sonar sweep. It steps the servo through N_POS positions in a ping-pong sweep and waits a settle time at each one. At each position it fires one distance measurement on the trena datapath, then one serial transmission of the result. It sits between the top-level sonar, the PWM position input, and the trena datapath handshakes, and replaces the free-running period counter and the pronto-driven position counter.

Parameters:
N_POS, 8, number of servo positions (minimum 2)
W_POS, 3, width of posicao (must satisfy 2^W_POS >= N_POS)
T_ACOMODA, 25000000, servo settle cycles per position
T_TIMEOUT, 5000000, maximum cycles to wait for medida_pronto

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; returns block to inicial
ligar  in  1  level enable for sweeping
medida_pronto  in  1  one-cycle pulse from datapath, measurement done
envio_pronto  in  1  one-cycle pulse from datapath, serial frame sent
medir  out  1  one-cycle pulse, start measurement
transmitir  out  1  one-cycle pulse, start transmission
posicao  out  W_POS  current servo position index, drives PWM width and angle ROM address
fim_posicao  out  1  one-cycle pulse, position cycle finished
timeout  out  1  one-cycle pulse, measurement timed out
ativo  out  1  high in every state except inicial
db_estado  out  4  state encoding for debug display

Behaviour:
- Reset (async) values: state inicial, posicao=0, direction=up, timer=0; all outputs 0; db_estado=0.
- All outputs are registered or decoded from the registered state. Pulses last exactly one clock.
- States and db_estado codes:
  - inicial (0): wait. If ligar=1, go to preparacao.
  - preparacao (1): posicao<=0, direction<=up, timer<=0. Next: acomoda.
  - acomoda (2): timer increments each cycle. At timer==T_ACOMODA-1, clear timer and go to dispara. Acomoda lasts exactly T_ACOMODA cycles.
  - dispara (3): medir=1. Timer cleared. Next: aguarda_medida.
  - aguarda_medida (4): timer increments.
    - If medida_pronto=1, go to envia.
    - Else if timer==T_TIMEOUT-1, go to falha.
    - If both occur in the same cycle, medida_pronto wins.
  - envia (5): transmitir=1. Next: aguarda_envio.
  - aguarda_envio (6): wait for envio_pronto. There is no timeout in this state. Next: proxima.
  - falha (7): timeout=1. Transmission is skipped. Next: proxima.
  - proxima (8): fim_posicao=1. posicao updates, then:
    - If ligar=1, go to acomoda with timer cleared.
    - Else go to inicial; posicao keeps its updated value.
- Sweep rule, evaluated in proxima:
  - up and posicao<N_POS-1: posicao+1.
  - up and posicao==N_POS-1: posicao-1, direction<=down.
  - down and posicao>0: posicao-1.
  - down and posicao==0: posicao+1, direction<=up.
  - Sequence for N_POS=8: 0,1,...,7,6,...,0,1,... Endpoints are visited once per turn. posicao never leaves [0, N_POS-1].
- ligar deassertion is graceful. It is sampled only in inicial and proxima, so an in-flight measurement or transmission always completes. Restart passes through preparacao, so posicao restarts at 0.
- medida_pronto outside aguarda_medida and envio_pronto outside aguarda_envio are ignored and never latched.
- Timer width is clog2(max(T_ACOMODA, T_TIMEOUT)). The timer never wraps inside a state.
- Reset asserted mid-cycle (any state) aborts immediately. No pulse may be emitted while reset is high.
- Unused state codes 9-15 go to inicial on the next clock.

Test Plan:
(Bench parameters for all scenarios: N_POS=4, T_ACOMODA=4, T_TIMEOUT=10.)
1. Basic cycle: reset, then ligar=1. Reply with medida_pronto 3 cycles after medir, and envio_pronto 5 cycles after transmitir. Required: db_estado goes 0,1, then 2 held 4 cycles, 3, 4, 5, 6, 8. medir and transmitir are single pulses. fim_posicao pulses once, and posicao becomes 1.
2. Full sweep: keep ligar=1 with auto-responses for 7 position cycles. Required: posicao sequence 0,1,2,3,2,1,0,1, and exactly one medir per position.
3. Timeout: never send medida_pronto. Required: exactly 10 cycles in state 4, then state 7 with timeout=1 for one cycle, no transmitir, then fim_posicao, and posicao advances.
4. Simultaneous: assert medida_pronto on the cycle where the timer reaches 9 in aguarda_medida. Required: next state 5, timeout stays 0.
5. Graceful stop: drop ligar during aguarda_envio at posicao=2, going up. Required: the transmission completes, fim_posicao pulses, posicao=3, state returns to 0, and ativo=0. Raising ligar again: preparacao, then posicao=0.
6. Async reset: assert reset mid-acomoda, between clock edges. Required: state 0, posicao=0, and all pulses 0 before the next edge. Spurious medida_pronto or envio_pronto in state 2 must cause no transition.

Source files
------------

// File: rtl/sonar_varredura_uc.sv
// Sonar sweep sequencer: steps the servo ping-pong through N_POS positions and, at each one,
// waits for the servo to settle, fires one measurement, then sends one serial frame.
module sonar_varredura_uc #(
   parameter int N_POS     = 8,
   parameter int W_POS     = 3,
   parameter int T_ACOMODA = 25000000,
   parameter int T_TIMEOUT = 5000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ligar,
   input  logic             medida_pronto,
   input  logic             envio_pronto,
   output logic             medir,
   output logic             transmitir,
   output logic [W_POS-1:0] posicao,
   output logic             fim_posicao,
   output logic             timeout,
   output logic             ativo,
   output logic [3:0]       db_estado
);

   localparam int T_MAX = (T_ACOMODA > T_TIMEOUT) ? T_ACOMODA : T_TIMEOUT;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TW-1:0]    FIM_ACOMODA = TW'(T_ACOMODA - 1);
   localparam logic [TW-1:0]    FIM_TIMEOUT = TW'(T_TIMEOUT - 1);
   localparam logic [W_POS-1:0] POS_MAX     = W_POS'(N_POS - 1);

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARACAO     = 4'd1,
      ACOMODA        = 4'd2,
      DISPARA        = 4'd3,
      AGUARDA_MEDIDA = 4'd4,
      ENVIA          = 4'd5,
      AGUARDA_ENVIO  = 4'd6,
      FALHA          = 4'd7,
      PROXIMA        = 4'd8
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [W_POS-1:0] posicao_q, posicao_d;
   logic             desce_q, desce_d;
   logic [TW-1:0]    timer_q, timer_d;

   logic [W_POS-1:0] posicao_prox;
   logic             desce_prox;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q  <= INICIAL;
         posicao_q <= '0;
         desce_q   <= 1'b0;
         timer_q   <= '0;
      end else begin
         estado_q  <= estado_d;
         posicao_q <= posicao_d;
         desce_q   <= desce_d;
         timer_q   <= timer_d;
      end
   end

   // Ping-pong step: each endpoint is visited once, then the direction flips.
   always_comb begin
      posicao_prox = posicao_q;
      desce_prox   = desce_q;
      if (!desce_q) begin
         if (posicao_q == POS_MAX) begin
            posicao_prox = posicao_q - W_POS'(1);
            desce_prox   = 1'b1;
         end else begin
            posicao_prox = posicao_q + W_POS'(1);
         end
      end else begin
         if (posicao_q == '0) begin
            posicao_prox = posicao_q + W_POS'(1);
            desce_prox   = 1'b0;
         end else begin
            posicao_prox = posicao_q - W_POS'(1);
         end
      end
   end

   // The timer defaults to zero so it only holds a count while a wait state is counting.
   always_comb begin
      estado_d  = estado_q;
      posicao_d = posicao_q;
      desce_d   = desce_q;
      timer_d   = '0;
      case (estado_q)
         INICIAL: begin
            if (ligar) estado_d = PREPARACAO;
         end
         PREPARACAO: begin
            posicao_d = '0;
            desce_d   = 1'b0;
            estado_d  = ACOMODA;
         end
         ACOMODA: begin
            if (timer_q == FIM_ACOMODA) estado_d = DISPARA;
            else                        timer_d  = timer_q + TW'(1);
         end
         DISPARA: begin
            estado_d = AGUARDA_MEDIDA;
         end
         AGUARDA_MEDIDA: begin
            if (medida_pronto)               estado_d = ENVIA;
            else if (timer_q == FIM_TIMEOUT) estado_d = FALHA;
            else                             timer_d  = timer_q + TW'(1);
         end
         ENVIA: begin
            estado_d = AGUARDA_ENVIO;
         end
         AGUARDA_ENVIO: begin
            if (envio_pronto) estado_d = PROXIMA;
         end
         FALHA: begin
            estado_d = PROXIMA;
         end
         PROXIMA: begin
            posicao_d = posicao_prox;
            desce_d   = desce_prox;
            estado_d  = ligar ? ACOMODA : INICIAL;
         end
         default: begin
            estado_d = INICIAL;
         end
      endcase
   end

   // Pulses are state decodes, so an async reset clears them immediately.
   assign medir       = (estado_q == DISPARA);
   assign transmitir  = (estado_q == ENVIA);
   assign fim_posicao = (estado_q == PROXIMA);
   assign timeout     = (estado_q == FALHA);
   assign ativo       = (estado_q != INICIAL);
   assign posicao     = posicao_q;
   assign db_estado   = estado_q;

endmodule

// File: tb/tb_sonar_varredura_uc.sv
// Self-checking bench for sonar_varredura_uc: directed scenarios plus a randomized phase,
// all compared every cycle against a position-count based reference model.
module tb_sonar_varredura_uc;

   localparam int N_POS = 4;
   localparam int W_POS = 2;
   localparam int T_AC  = 4;
   localparam int T_TO  = 10;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             ligar = 1'b0;
   logic             auto_mp = 1'b0, man_mp = 1'b0;
   logic             auto_ep = 1'b0, man_ep = 1'b0;
   logic             medida_pronto, envio_pronto;
   logic             medir, transmitir, fim_posicao, timeout, ativo;
   logic [W_POS-1:0] posicao;
   logic [3:0]       db_estado;

   assign medida_pronto = auto_mp | man_mp;
   assign envio_pronto  = auto_ep | man_ep;

   sonar_varredura_uc #(
      .N_POS(N_POS), .W_POS(W_POS), .T_ACOMODA(T_AC), .T_TIMEOUT(T_TO)
   ) dut (
      .clock(clock), .reset(reset), .ligar(ligar),
      .medida_pronto(medida_pronto), .envio_pronto(envio_pronto),
      .medir(medir), .transmitir(transmitir), .posicao(posicao),
      .fim_posicao(fim_posicao), .timeout(timeout), .ativo(ativo),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase code, cycles left in a wait, positions completed since start.
   typedef struct packed {
      int st;
      int left;
      int k;
   } mdl_t;

   mdl_t m;

   function automatic int pingpong(input int k);
      int per = 2 * (N_POS - 1);
      int r   = k % per;
      return (r < N_POS) ? r : per - r;
   endfunction

   function automatic mdl_t step(input mdl_t s, input logic lg, input logic mp, input logic ep);
      mdl_t n = s;
      case (s.st)
         0: if (lg) n.st = 1;
         1: begin n.k = 0; n.left = T_AC; n.st = 2; end
         2: begin n.left = s.left - 1; if (n.left == 0) n.st = 3; end
         3: begin n.left = T_TO; n.st = 4; end
         4: begin
            n.left = s.left - 1;
            if (mp)               n.st = 5;
            else if (n.left == 0) n.st = 7;
         end
         5: n.st = 6;
         6: if (ep) n.st = 8;
         7: n.st = 8;
         8: begin n.k = s.k + 1; n.left = T_AC; n.st = lg ? 2 : 0; end
         default: n.st = 0;
      endcase
      return n;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) m <= '{st: 0, left: 0, k: 0};
      else       m <= step(m, ligar, medida_pronto, envio_pronto);
   end

   bit cmp_en = 1'b0;

   initial forever begin
      @(negedge clock);
      if (cmp_en && !reset) begin
         check("db_estado",   int'(db_estado),   m.st);
         check("posicao",     int'(posicao),     pingpong(m.k));
         check("medir",       int'(medir),       int'(m.st == 3));
         check("transmitir",  int'(transmitir),  int'(m.st == 5));
         check("timeout",     int'(timeout),     int'(m.st == 7));
         check("fim_posicao", int'(fim_posicao), int'(m.st == 8));
         check("ativo",       int'(ativo),       int'(m.st != 0));
      end
   end

   // Datapath stand-in: answers medir/transmitir after a delay drawn from [lo, hi].
   bit mp_en = 1'b1;
   int mp_lo = 3, mp_hi = 3, ep_lo = 5, ep_hi = 5;

   initial begin
      int mp_cnt = 0;
      int ep_cnt = 0;
      forever begin
         @(negedge clock);
         auto_mp = 1'b0;
         auto_ep = 1'b0;
         if (reset) begin
            mp_cnt = 0;
            ep_cnt = 0;
         end else begin
            if (mp_cnt == 1) auto_mp = 1'b1;
            if (mp_cnt > 0)  mp_cnt--;
            if (ep_cnt == 1) auto_ep = 1'b1;
            if (ep_cnt > 0)  ep_cnt--;
            if (medir && mp_en) mp_cnt = int'($urandom_range(mp_hi, mp_lo));
            if (transmitir)     ep_cnt = int'($urandom_range(ep_hi, ep_lo));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_medir(input string nm);
      int n = 0;
      while (!medir && n < 100) begin
         @(negedge clock);
         n++;
      end
      check(nm, int'(medir), 1);
   endtask

   int exp1[18] = '{0, 1, 2, 2, 2, 2, 3, 4, 4, 4, 5, 6, 6, 6, 6, 6, 8, 2};
   int sweep[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

   initial begin
      int tr_st[18];
      int tr_pos[18];
      int nmed, ntx, nfim, ntmo, n4, cyc;

      repeat (2) @(negedge clock);
      check("reset_estado",  int'(db_estado), 0);
      check("reset_posicao", int'(posicao), 0);
      check("reset_ativo",   int'(ativo), 0);
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Basic cycle with fixed response delays
      @(negedge clock);
      nmed = 0; ntx = 0; nfim = 0;
      for (int i = 0; i < 18; i++) begin
         if (i > 0) @(negedge clock);
         tr_st[i]  = int'(db_estado);
         tr_pos[i] = int'(posicao);
         nmed += int'(medir);
         ntx  += int'(transmitir);
         nfim += int'(fim_posicao);
         if (i == 0) ligar = 1'b1;
      end
      for (int i = 0; i < 18; i++) check("basic_trace", tr_st[i], exp1[i]);
      check("basic_medir_count", nmed, 1);
      check("basic_tx_count",    ntx, 1);
      check("basic_fim_count",   nfim, 1);
      check("basic_pos_at_fim",  tr_pos[16], 0);
      check("basic_pos_after",   tr_pos[17], 1);

      // Full sweep with random in-time responses
      mp_lo = 1; mp_hi = 9; ep_lo = 1; ep_hi = 9;
      for (int p = 1; p < 8; p++) begin
         nmed = 0;
         cyc  = 0;
         do begin
            @(negedge clock);
            nmed += int'(medir);
            cyc++;
         end while (!fim_posicao && cyc < 200);
         check("sweep_fim_seen", int'(fim_posicao), 1);
         check("sweep_posicao",  int'(posicao), sweep[p]);
         check("sweep_medir_per_pos", nmed, 1);
      end

      // Measurement never answered: timeout path at posicao 2
      mp_en = 1'b0;
      wait_medir("timeout_medir_seen");
      n4 = 0; ntx = 0; ntmo = 0;
      @(negedge clock);
      while (db_estado == 4'd4 && n4 < 50) begin
         n4++;
         ntx  += int'(transmitir);
         ntmo += int'(timeout);
         @(negedge clock);
      end
      check("timeout_wait_cycles", n4, 10);
      check("timeout_early_pulse", ntmo, 0);
      check("timeout_state",       int'(db_estado), 7);
      check("timeout_pulse",       int'(timeout), 1);
      check("timeout_posicao",     int'(posicao), 2);
      ntx += int'(transmitir);
      @(negedge clock);
      ntx += int'(transmitir);
      check("timeout_fim",         int'(fim_posicao), 1);
      check("timeout_no_tx",       ntx, 0);
      @(negedge clock);
      check("timeout_pos_advance", int'(posicao), 3);
      mp_en = 1'b1;

      // medida_pronto coincides with the last timeout cycle
      mp_lo = 10; mp_hi = 10;
      wait_medir("simul_medir_seen");
      n4 = 0; ntmo = 0;
      @(negedge clock);
      while (db_estado == 4'd4 && n4 < 50) begin
         n4++;
         ntmo += int'(timeout);
         @(negedge clock);
      end
      check("simul_wait_cycles", n4, 10);
      check("simul_state",       int'(db_estado), 5);
      check("simul_no_timeout",  ntmo + int'(timeout), 0);
      mp_lo = 3; mp_hi = 3; ep_lo = 5; ep_hi = 5;

      // Graceful stop during aguarda_envio at posicao 2, sweeping up
      cyc = 0;
      while (!(db_estado == 4'd6 && (m.k % 6) == 2) && cyc < 500) begin
         @(negedge clock);
         cyc++;
      end
      check("stop_reached", int'(db_estado), 6);
      check("stop_posicao", int'(posicao), 2);
      ligar = 1'b0;
      cyc = 0;
      while (!fim_posicao && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      check("stop_fim", int'(fim_posicao), 1);
      repeat (2) @(negedge clock);
      check("stop_state",   int'(db_estado), 0);
      check("stop_posicao_after", int'(posicao), 3);
      check("stop_ativo",   int'(ativo), 0);
      repeat (3) @(negedge clock);
      check("stop_idle",    int'(db_estado), 0);
      ligar = 1'b1;
      @(negedge clock);
      check("restart_prep", int'(db_estado), 1);
      @(negedge clock);
      check("restart_acomoda", int'(db_estado), 2);
      check("restart_posicao", int'(posicao), 0);

      // Spurious handshakes in acomoda, then async reset mid-acomoda at posicao 2
      cyc = 0;
      while (!(db_estado == 4'd2 && posicao == 2'd2) && cyc < 200) begin
         @(negedge clock);
         cyc++;
      end
      check("areset_setup_pos", int'(posicao), 2);
      man_mp = 1'b1;
      man_ep = 1'b1;
      @(negedge clock);
      man_mp = 1'b0;
      man_ep = 1'b0;
      check("spurious_no_move", int'(db_estado), 2);
      #2 reset = 1'b1;
      #1;
      check("areset_estado",  int'(db_estado), 0);
      check("areset_posicao", int'(posicao), 0);
      check("areset_pulses",  int'({medir, transmitir, fim_posicao, timeout}), 0);
      check("areset_ativo",   int'(ativo), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Randomized phase: random delays (including timeouts), ligar drops, stray pulses
      mp_lo = 1; mp_hi = 14; ep_lo = 1; ep_hi = 12;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         ligar  = ($urandom_range(19, 0) != 0);
         man_mp = ($urandom_range(15, 0) == 0);
         man_ep = ($urandom_range(15, 0) == 0);
      end
      man_mp = 1'b0;
      man_ep = 1'b0;
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
